// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_rx receiver.
package uart_pkg;

    // Receiver frame states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity mode encodings for PARITY_ODD
    localparam logic PARITY_EVEN     = 1'b0;
    localparam logic PARITY_ODD_MODE = 1'b1;

    // Width of the per-bit tick counter for a given oversample ratio
    function automatic int unsigned tick_width(input int unsigned oversample);
        return (oversample <= 2) ? 1 : $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop input synchroniser plus 3-sample majority voter.
// Two samples are captured on 'sample' strobes; the third is the live rx_s,
// so vote_c is valid in the cycle of the decision tick.
module uart_rx_sampler (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic sample,
    output logic rx_s,
    output logic vote_c
);

    logic       rx_meta;
    logic [1:0] hist;

    // Synchroniser (idle-high reset) and sample history
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            hist    <= 2'b11;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            if (sample) begin
                hist <= {hist[0], rx_s};
            end
        end
    end

    // Majority of the two stored samples and the current one
    always_comb begin
        vote_c = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: parametrised UART receiver with majority sampling, false-start
// rejection, valid/ready output handshake and frame/parity/overrun flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int unsigned TW   = tick_width(OVERSAMPLE);
    localparam int unsigned BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned HALF = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_S0   = TW'(HALF - 1);
    localparam logic [TW-1:0] T_S1   = TW'(HALF);
    localparam logic [TW-1:0] T_DEC  = TW'(HALF + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_ODD_MODE : PARITY_EVEN;

    rx_state_t            state, state_next;
    logic [TW-1:0]        tcnt, tcnt_next;
    logic [BW-1:0]        bcnt, bcnt_next;
    logic                 scnt, scnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 ferr, ferr_next;
    logic                 rx_s;
    logic                 vote_c;
    logic                 sample_c;
    logic                 deliver_c;
    logic                 perr_c;
    logic                 dec;
    logic                 wrap;
`ifdef UART_RX_PARITY_EN
    logic                 pbit, pbit_next;
`endif

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .reset  (reset),
        .rx_in  (rx_in),
        .sample (sample_c),
        .rx_s   (rx_s),
        .vote_c (vote_c)
    );

    assign dec  = (tcnt == T_DEC);
    assign wrap = (tcnt == T_LAST);

    // State and frame datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            scnt  <= 1'b0;
            shreg <= '0;
            ferr  <= 1'b0;
            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            tcnt  <= tcnt_next;
            bcnt  <= bcnt_next;
            scnt  <= scnt_next;
            shreg <= shreg_next;
            ferr  <= ferr_next;
            busy  <= (state_next != IDLE);
`ifdef UART_RX_PARITY_EN
            pbit  <= pbit_next;
`endif
        end
    end

    // Next-state, counters and bit decisions; everything advances on baud_tick
    always_comb begin
        state_next = state;
        tcnt_next  = tcnt;
        bcnt_next  = bcnt;
        scnt_next  = scnt;
        shreg_next = shreg;
        ferr_next  = ferr;
        sample_c   = 1'b0;
        deliver_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbit_next  = pbit;
`endif
        if (baud_tick) begin
            tcnt_next = wrap ? '0 : tcnt + TW'(1);
            sample_c  = (state != IDLE) && ((tcnt == T_S0) || (tcnt == T_S1));
            case (state)
                IDLE: begin
                    tcnt_next = '0;
                    if (!rx_s) begin
                        // the detecting tick is tick 0, so the next one is tick 1
                        state_next = START;
                        tcnt_next  = TW'(1);
                    end
                end
                START: begin
                    if (dec && vote_c) begin
                        state_next = IDLE;
                        tcnt_next  = '0;
                    end else if (wrap) begin
                        state_next = DATA;
                        bcnt_next  = '0;
                    end
                end
                DATA: begin
                    if (dec) begin
                        shreg_next = {vote_c, shreg[DATA_BITS-1:1]};
                    end
                    if (wrap) begin
                        if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
                            scnt_next  = 1'b0;
                            ferr_next  = 1'b0;
`endif
                        end else begin
                            bcnt_next = bcnt + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (dec) begin
                        pbit_next = vote_c;
                    end
                    if (wrap) begin
                        state_next = STOP;
                        scnt_next  = 1'b0;
                        ferr_next  = 1'b0;
                    end
                end
`endif
                STOP: begin
                    if (dec) begin
                        if (!vote_c) begin
                            ferr_next = 1'b1;
                        end
                        if (scnt == S_LAST) begin
                            // leave early so a back-to-back start edge is seen
                            state_next = IDLE;
                            tcnt_next  = '0;
                            deliver_c  = 1'b1;
                        end
                    end else if (wrap) begin
                        scnt_next = scnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    tcnt_next  = '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign perr_c = (((^shreg) ^ pbit) != PAR_MODE);
`else
    // no parity bit in the frame
    assign perr_c = PAR_MODE & 1'b0;
`endif

    // Output word register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (deliver_c) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    frame_err  <= ferr_next;
                    parity_err <= perr_c;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (8 data bits, 16x, 1 stop).
// Honours UART_RX_PARITY_EN for the frame format and expected parity flags.
module tb_uart_rx;

    localparam int unsigned DB = 8;
    localparam int unsigned OS = 16;
    localparam int unsigned SB = 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // rx_in edge to data_valid: 2 sync clks + decision tick offset + 1 clk
    localparam int LATENCY = 2 + (1 + int'(DB) + (PAR_EN ? 1 : 0) + int'(SB) - 1) * int'(OS)
                             + int'(OS) / 2 + 1 + 1;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_low;
        logic       par_bad;
        logic       glitch;
        int         div;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          baud_tick;
    logic          rx_in;
    logic          data_ready;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun_err;
    logic          busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc = -1000;
    int   dv_rises = 0;
    int   ov_count = 0;
    int   div_cur = 1;
    int   bdiv_cnt = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[7];

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS),
        .STOP_BITS  (SB),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // baud_tick every div_cur clks
    initial begin
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bdiv_cnt + 1 >= div_cur) begin
                bdiv_cnt  = 0;
                baud_tick = 1'b1;
            end else begin
                bdiv_cnt  = bdiv_cnt + 1;
                baud_tick = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshake, counts rises and overruns
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid && !prev_valid) begin
                rise_cyc = cyc;
                dv_rises = dv_rises + 1;
            end
            if (overrun_err) ov_count = ov_count + 1;
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL sb_unexpected_word: got %02h expected no word", data_out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_data", 32'(data_out), 32'(mon_e.data));
                    chk("sb_frame_err", 32'(frame_err), 32'(mon_e.ferr));
                    chk("sb_parity_err", 32'(parity_err), 32'(mon_e.perr));
                end
            end
        end
        prev_valid = data_valid;
    end

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_low, input logic par_bad,
                              input logic glitch, input int div, input bit push,
                              input logic ef, input logic ep);
        int   bt;
        exp_t e;
        bt = int'(OS) * div;
        div_cur = div;
        if (push) begin
            e.data = d;
            e.ferr = ef;
            e.perr = ep;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0, bt);
        for (int i = 0; i < int'(DB); i++) begin
            if (glitch && i == 0) begin
                // one-clk flip that hits only the centre sample of bit 0
                drive_bit(d[0], 8);
                drive_bit(~d[0], 1);
                drive_bit(d[0], bt - 9);
            end else begin
                drive_bit(d[i], bt);
            end
        end
        if (PAR_EN) drive_bit((^d) ^ par_bad, bt);
        for (int s = 0; s < int'(SB); s++) drive_bit((s == 0) ? ~stop_low : 1'b1, bt);
        rx_in = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int dv_base;
        int ov_base;

        vecs[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b0};
        vecs[4] = '{8'h96, 1'b0, 1'b0, 1'b0, 3, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b1, 1'b0, 1, 8'h07, 1'b0, PAR_EN};
        vecs[6] = '{8'h07, 1'b0, 1'b0, 1'b0, 1, 8'h07, 1'b0, 1'b0};

        reset      = 1'b1;
        rx_in      = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_overrun_err", 32'(overrun_err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // 0xA5 latency, then hold with data_ready low
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        chk("latency_clks", 32'(rise_cyc - start_cyc), 32'(LATENCY));
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("hold_valid", 32'(data_valid), 32'h1);
        chk("hold_data", 32'(data_out), 32'hA5);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("consume_clears_valid", 32'(data_valid), 32'h0);

        // Table-driven frames, consumer always ready
        for (int v = 0; v < 7; v++) begin
            if (PAR_EN || v < 5 || v == 6) begin
                send_frame(vecs[v].data, vecs[v].stop_low, vecs[v].par_bad, vecs[v].glitch,
                           vecs[v].div, 1'b1, vecs[v].exp_ferr, vecs[v].exp_perr);
                repeat (2 * int'(OS) * vecs[v].div) @(posedge clk);
            end
        end
        div_cur = 1;
        repeat (4) @(posedge clk);

        // Short low glitch on idle line: false start, no word
        dv_base = dv_rises;
        @(posedge clk);
        #1;
        rx_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_in = 1'b1;
        @(negedge clk);
        chk("glitch_busy_enter", 32'(busy), 32'h1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_exit", 32'(busy), 32'h0);
        chk("glitch_no_word", 32'(dv_rises), 32'(dv_base));

        // Back-to-back frames with consumer stalled: one overrun
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        ov_base = ov_count;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("overrun_keep_data", 32'(data_out), 32'h11);
        chk("overrun_keep_valid", 32'(data_valid), 32'h1);
        chk("overrun_pulses", 32'(ov_count - ov_base), 32'h1);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("overrun_valid_cleared", 32'(data_valid), 32'h0);

        // Reset in the middle of data bit 4, then a clean frame
        dv_base = dv_rises;
        @(posedge clk);
        #1;
        drive_bit(1'b0, int'(OS));
        for (int i = 0; i < 4; i++) drive_bit(1'b1, int'(OS));
        rx_in = 1'b0;
        repeat (int'(OS) / 2) @(posedge clk);
        @(negedge clk);
        chk("midframe_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        rx_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset_busy_clear", 32'(busy), 32'h0);
        chk("reset_no_valid", 32'(data_valid), 32'h0);
        reset = 1'b0;
        repeat (3 * int'(OS)) @(posedge clk);
        @(negedge clk);
        chk("reset_no_delivery", 32'(dv_rises), 32'(dv_base));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        repeat (2 * int'(OS)) @(posedge clk);
        @(negedge clk);
        chk("post_reset_one_word", 32'(dv_rises), 32'(dv_base + 1));
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
